// File: rtl/maze_pkg.sv
// Shared maze definitions: screen geometry, tile codes and palette.
package maze_pkg;

    localparam int H_OFFSET   = 144;
    localparam int V_OFFSET   = 35;
    localparam int TILE_SHIFT = 5;
    localparam int MAZE_W     = 20;
    localparam int MAZE_H     = 15;

    typedef enum logic [1:0] {
        TILE_FLOOR = 2'd0,
        TILE_WALL  = 2'd1,
        TILE_GOAL  = 2'd2,
        TILE_SPARE = 2'd3
    } tile_t;

    localparam logic [11:0] C_FLOOR  = 12'h000;
    localparam logic [11:0] C_WALL   = 12'h00F;
    localparam logic [11:0] C_GOAL   = 12'h0F0;
    localparam logic [11:0] C_PLAYER = 12'hF00;

    // Palette lookup; the spare code renders as floor.
    function automatic logic [11:0] tile_colour(input tile_t t);
        logic [11:0] c;
        case (t)
            TILE_WALL: c = C_WALL;
            TILE_GOAL: c = C_GOAL;
            default:   c = C_FLOOR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/maze_tile_addr.sv
// Pixel (x, y) relative to the visible origin -> tile column/row, offset
// inside the tile, in-grid flag and linear tile RAM address.
module maze_tile_addr
    import maze_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [4:0] col,
    output logic [4:0] row,
    output logic [4:0] x_lo,
    output logic [4:0] y_lo,
    output logic       in_grid,
    output logic [8:0] addr
);

    assign col  = x[TILE_SHIFT +: 5];
    assign row  = y[TILE_SHIFT +: 5];
    assign x_lo = x[4:0];
    assign y_lo = y[4:0];

    // Negative offsets wrap to large values and land outside the grid.
    assign in_grid = (col < 5'(MAZE_W)) && (row < 5'(MAZE_H));

    // row*20 + col built from shifts: row*16 + row*4 + col.
    assign addr = {row, 4'b0000} + {2'b00, row, 2'b00} + {4'b0000, col};

endmodule

// File: rtl/maze_pixel_reader.sv
// Read side of the maze tile RAM: three-stage pixel pipeline that looks up
// the tile under the beam, overlays the player marker and emits rgb with
// syncs and bright delayed by the same number of pixel ticks.
module maze_pixel_reader
    import maze_pkg::*;
(
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        bright,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [4:0]  player_col,
    input  logic [3:0]  player_row,
    input  logic        win,
    output logic [8:0]  rd_addr,
    input  logic [1:0]  rd_data,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        bright_out
);

    logic [9:0] x_p0, y_p0;
    logic [4:0] col_p0, row_p0, xlo_p0, ylo_p0;
    logic       grid_p0;
    logic [8:0] addr_p0;

    logic [4:0] col_p1, row_p1, xlo_p1, ylo_p1;
    logic       vld_p1, bright_p1, hsync_p1, vsync_p1;

    logic [4:0] col_p2, row_p2, xlo_p2, ylo_p2;
    logic       vld_p2, bright_p2, hsync_p2, vsync_p2;
    tile_t      tile_p2;

    logic [4:0] frame_cnt;
    logic       player_p2;

    // Stage 3 colour select: blank outside the grid, then marker, then tile.
    function automatic logic [11:0] pick_colour(input logic vld, input logic is_player,
                                                input tile_t t);
        logic [11:0] c;
        if (!vld)
            c = 12'h000;
        else if (is_player)
            c = C_PLAYER;
        else
            c = tile_colour(t);
        return c;
    endfunction

    // ---- stage 0: beam position relative to the visible origin
    assign x_p0 = hc - 10'(H_OFFSET);
    assign y_p0 = vc - 10'(V_OFFSET);

    maze_tile_addr u_tile_addr (
        .x       (x_p0),
        .y       (y_p0),
        .col     (col_p0),
        .row     (row_p0),
        .x_lo    (xlo_p0),
        .y_lo    (ylo_p0),
        .in_grid (grid_p0),
        .addr    (addr_p0)
    );

    // ---- stage 1: issue the RAM address and register the sideband
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            rd_addr   <= '0;
            vld_p1    <= 1'b0;
            col_p1    <= '0;
            row_p1    <= '0;
            xlo_p1    <= '0;
            ylo_p1    <= '0;
            bright_p1 <= 1'b0;
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
        end else if (pix_en) begin
            if (bright && grid_p0)
                rd_addr <= addr_p0;
            vld_p1    <= bright && grid_p0;
            col_p1    <= col_p0;
            row_p1    <= row_p0;
            xlo_p1    <= xlo_p0;
            ylo_p1    <= ylo_p0;
            bright_p1 <= bright;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
        end
    end

    // Frame counter steps on each vsync_in falling edge seen at pixel rate.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset)
            frame_cnt <= '0;
        else if (pix_en && vsync_p1 && !vsync_in)
            frame_cnt <= frame_cnt + 5'd1;
    end

    // ---- stage 2: RAM data has settled for several cycles; capture it
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            tile_p2   <= TILE_FLOOR;
            vld_p2    <= 1'b0;
            col_p2    <= '0;
            row_p2    <= '0;
            xlo_p2    <= '0;
            ylo_p2    <= '0;
            bright_p2 <= 1'b0;
            hsync_p2  <= 1'b1;
            vsync_p2  <= 1'b1;
        end else if (pix_en) begin
            tile_p2   <= tile_t'(rd_data);
            vld_p2    <= vld_p1;
            col_p2    <= col_p1;
            row_p2    <= row_p1;
            xlo_p2    <= xlo_p1;
            ylo_p2    <= ylo_p1;
            bright_p2 <= bright_p1;
            hsync_p2  <= hsync_p1;
            vsync_p2  <= vsync_p1;
        end
    end

    // ---- stage 3: marker is the centre 16x16 of the player tile, blinking on win
    assign player_p2 = (col_p2 == player_col) && (row_p2 == {1'b0, player_row}) &&
                       (xlo_p2 >= 5'd8) && (xlo_p2 <= 5'd23) &&
                       (ylo_p2 >= 5'd8) && (ylo_p2 <= 5'd23) &&
                       !(win && frame_cnt[4]);

    // Output registers: colour and delayed syncs/bright move together.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            rgb        <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            bright_out <= 1'b0;
        end else if (pix_en) begin
            rgb        <= pick_colour(vld_p2, player_p2, tile_p2);
            hsync      <= hsync_p2;
            vsync      <= vsync_p2;
            bright_out <= bright_p2;
        end
    end

endmodule

// File: tb/tb_maze_pixel_reader.sv
// Bench for maze_pixel_reader: tile RAM model, reference pixel model and a
// scoreboard queue of expected outputs popped as the pipeline drains.
module tb_maze_pixel_reader;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        br;
    } exp_t;

    logic        ClkPort = 1'b0;
    logic        Reset = 1'b1;
    logic        pix_en = 1'b0;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic        bright = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [4:0]  player_col = 5'd10;
    logic [3:0]  player_row = 4'd10;
    logic        win = 1'b0;
    logic [8:0]  rd_addr;
    logic [1:0]  rd_data = '0;
    logic [11:0] rgb;
    logic        hsync, vsync, bright_out;

    logic [1:0]  ram [0:511];
    exp_t        sb[$];
    int          m_fc;
    logic        m_prev_v;
    logic [8:0]  m_addr;
    int          errors = 0;
    int          checks = 0;

    maze_pixel_reader dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .pix_en     (pix_en),
        .hc         (hc),
        .vc         (vc),
        .bright     (bright),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .player_col (player_col),
        .player_row (player_row),
        .win        (win),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .bright_out (bright_out)
    );

    always #5 ClkPort = ~ClkPort;

    // Synchronous-read tile RAM, one cycle of latency.
    always @(posedge ClkPort) rd_data <= ram[rd_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] model_rgb();
        int x, y, col, row;
        x = int'(hc) - 144;
        y = int'(vc) - 35;
        if (!bright || x < 0 || y < 0 || x >= 640 || y >= 480) return 12'h000;
        col = x / 32;
        row = y / 32;
        if (col == int'(player_col) && row == int'(player_row) &&
            (x % 32) >= 8 && (x % 32) <= 23 && (y % 32) >= 8 && (y % 32) <= 23 &&
            !(win && m_fc >= 16))
            return 12'hF00;
        case (ram[row * 20 + col])
            2'd1:    return 12'h00F;
            2'd2:    return 12'h0F0;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        sb.delete();
        m_fc = 0;
        m_prev_v = 1'b1;
        m_addr = '0;
    endtask

    // One pixel tick: strobe pix_en, update the model, push the expectation
    // and hand back the entry that leaves the pipeline on this tick.
    task automatic tick(output bit have, output exp_t e);
        exp_t n;
        int   x, y;
        @(negedge ClkPort);
        pix_en = 1'b1;
        @(posedge ClkPort);
        #1;
        pix_en = 1'b0;
        if (m_prev_v && !vsync_in) m_fc = (m_fc + 1) % 32;
        m_prev_v = vsync_in;
        n.rgb = model_rgb();
        n.hs  = hsync_in;
        n.vs  = vsync_in;
        n.br  = bright;
        x = int'(hc) - 144;
        y = int'(vc) - 35;
        if (bright && x >= 0 && y >= 0 && x < 640 && y < 480)
            m_addr = 9'((y / 32) * 20 + (x / 32));
        sb.push_back(n);
        have = 1'b0;
        e = '0;
        if (sb.size() > 2) begin
            have = 1'b1;
            e = sb.pop_front();
        end
        repeat (3) @(posedge ClkPort);
        #1;
    endtask

    task automatic test_reset();
        bit   have;
        exp_t e;
        Reset = 1'b1;
        repeat (5) @(posedge ClkPort);
        #1;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        checks++; if (bright_out !== 1'b0) begin errors++; $display("FAIL reset_bright got=%b exp=0", bright_out); end
        checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
        @(negedge ClkPort);
        Reset = 1'b0;
        model_reset();
        bright = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(have, e);
            checks++;
            if (rgb !== 12'h000) begin errors++; $display("FAIL reset_release_rgb tick=%0d got=%h exp=000", i, rgb); end
        end
    endtask

    task automatic test_addr_map();
        bit   have;
        exp_t e;
        bright = 1'b1;
        hc = 10'(144 + 32 * 19 + 5);
        vc = 10'(35 + 32 * 14 + 7);
        tick(have, e);
        checks++; if (rd_addr !== 9'd299) begin errors++; $display("FAIL addr_map_299 got=%0d exp=299", rd_addr); end
        if (have) begin checks++; if (rgb !== e.rgb) begin errors++; $display("FAIL addr_map_rgb got=%h exp=%h", rgb, e.rgb); end end
        hc = 10'd144;
        vc = 10'd35;
        tick(have, e);
        checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL addr_map_0 got=%0d exp=0", rd_addr); end
        if (have) begin checks++; if (rgb !== e.rgb) begin errors++; $display("FAIL addr_map_rgb got=%h exp=%h", rgb, e.rgb); end end
    endtask

    task automatic test_latency();
        bit   have;
        exp_t e;
        bright = 1'b0;
        for (int i = 0; i < 2; i++) tick(have, e);
        for (int i = 0; i < 36; i++) begin
            bright   = (i < 32);
            hc       = 10'(176 + (i % 32));
            vc       = 10'd67;
            hsync_in = ((i % 6) < 3);
            vsync_in = ((i % 10) < 7);
            tick(have, e);
            if (have) begin
                checks++;
                if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs || bright_out !== e.br) begin
                    errors++;
                    $display("FAIL latency tick=%0d got rgb=%h hs=%b vs=%b br=%b exp rgb=%h hs=%b vs=%b br=%b",
                             i, rgb, hsync, vsync, bright_out, e.rgb, e.hs, e.vs, e.br);
                end
            end
            if (i == 2) begin
                checks++;
                if (rgb !== 12'h00F) begin errors++; $display("FAIL latency_first_wall got=%h exp=00F", rgb); end
            end
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
    endtask

    task automatic test_player();
        bit   have;
        exp_t e;
        int   xs [6] = '{7, 8, 24, 23, 8, 16};
        int   ys [6] = '{8, 8, 8, 23, 7, 24};
        ram[21] = 2'd0;
        player_col = 5'd1;
        player_row = 4'd1;
        win = 1'b0;
        bright = 1'b0;
        for (int i = 0; i < 2; i++) tick(have, e);
        for (int i = 0; i < 8; i++) begin
            bright = (i < 6);
            hc = 10'(176 + xs[i % 6]);
            vc = 10'(67 + ys[i % 6]);
            tick(have, e);
            if (have) begin
                checks++;
                if (rgb !== e.rgb) begin errors++; $display("FAIL player tick=%0d got=%h exp=%h", i, rgb, e.rgb); end
            end
        end
        ram[21] = 2'd1;
    endtask

    task automatic test_blank();
        bit   have;
        exp_t e;
        logic [9:0] hs [4] = '{10'd176, 10'd304, 10'd784, 10'd176};
        logic [9:0] vs [4] = '{10'd67, 10'd131, 10'd67, 10'd515};
        logic       bs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            hc = hs[i % 4]; vc = vs[i % 4]; bright = (i < 4) ? bs[i] : 1'b0;
            tick(have, e);
            checks++;
            if (rd_addr !== 9'd21) begin errors++; $display("FAIL blank_addr tick=%0d got=%0d exp=21", i, rd_addr); end
            if (have) begin
                checks++;
                if (rgb !== e.rgb) begin errors++; $display("FAIL blank_rgb tick=%0d got=%h exp=%h", i, rgb, e.rgb); end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit   have;
        exp_t e;
        win = 1'b0;
        hsync_in = 1'b0;
        bright = 1'b1;
        hc = 10'd180; vc = 10'd70;
        for (int i = 0; i < 4; i++) begin
            tick(have, e);
            if (have) begin
                checks++;
                if (rgb !== e.rgb || hsync !== e.hs) begin errors++; $display("FAIL mid_pre got rgb=%h hs=%b exp rgb=%h hs=%b", rgb, hsync, e.rgb, e.hs); end
            end
        end
        #3;
        Reset = 1'b1;
        #1;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mid_reset_rgb got=%h exp=000", rgb); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL mid_reset_hsync got=%b exp=1", hsync); end
        checks++; if (bright_out !== 1'b0) begin errors++; $display("FAIL mid_reset_bright got=%b exp=0", bright_out); end
        repeat (2) @(posedge ClkPort);
        @(negedge ClkPort);
        Reset = 1'b0;
        model_reset();
        bright = 1'b0; hsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(have, e);
            checks++;
            if (rgb !== 12'h000) begin errors++; $display("FAIL mid_release_rgb tick=%0d got=%h exp=000", i, rgb); end
        end
    endtask

    task automatic test_win_blink();
        bit   have;
        exp_t e;
        Reset = 1'b1;
        repeat (2) @(posedge ClkPort);
        @(negedge ClkPort);
        Reset = 1'b0;
        model_reset();
        ram[21] = 2'd1;
        player_col = 5'd1; player_row = 4'd1;
        win = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        for (int f = 0; f < 33; f++) begin
            for (int k = 0; k < 5; k++) begin
                bright   = (k == 0);
                hc       = 10'd188;
                vc       = 10'd79;
                vsync_in = (k != 3);
                tick(have, e);
                if (have) begin
                    checks++;
                    if (rgb !== e.rgb) begin errors++; $display("FAIL blink frame=%0d k=%0d got=%h exp=%h", f, k, rgb, e.rgb); end
                end
                if (k == 2) begin
                    checks++;
                    if (rgb !== (((f % 32) < 16) ? 12'hF00 : 12'h00F)) begin
                        errors++;
                        $display("FAIL blink_phase frame=%0d got=%h exp=%h", f, rgb, ((f % 32) < 16) ? 12'hF00 : 12'h00F);
                    end
                end
            end
        end
        win = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 2'd0;
        ram[21]  = 2'd1;
        ram[22]  = 2'd2;
        ram[0]   = 2'd2;
        ram[299] = 2'd1;
        model_reset();
        test_reset();
        test_addr_map();
        test_latency();
        test_player();
        test_blank();
        test_mid_reset();
        test_win_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
